// File: rtl/wb_collector_pkg.sv
// Shared types for the writeback collector: the functional-unit result record,
// the stored buffer entry (valid implied by occupancy) and default sizing.
package wb_collector_pkg;

    localparam int WB_FU_NUM       = 4;
    localparam int WB_FIFO_DEPTH   = 8;
    localparam int WB_STALL_MARGIN = 2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  destination;
        logic [5:0]  ticket;
        logic [31:0] data;
        logic        valid_exception;
        logic [3:0]  cause;
    } ex_update;

    typedef struct packed {
        logic [4:0]  destination;
        logic [5:0]  ticket;
        logic [31:0] data;
        logic        valid_exception;
        logic [3:0]  cause;
    } wb_entry;

    function automatic wb_entry to_entry(ex_update u);
        wb_entry e;
        e.destination     = u.destination;
        e.ticket          = u.ticket;
        e.data            = u.data;
        e.valid_exception = u.valid_exception;
        e.cause           = u.cause;
        return e;
    endfunction

    function automatic ex_update from_entry(wb_entry e);
        ex_update u;
        u.valid           = 1'b1;
        u.destination     = e.destination;
        u.ticket          = e.ticket;
        u.data            = e.data;
        u.valid_exception = e.valid_exception;
        u.cause           = e.cause;
        return u;
    endfunction

endpackage

// File: rtl/wb_collector_if.sv
// Bundle of the functional-unit result ports and the single writeback port.
interface wb_collector_if
    import wb_collector_pkg::*;
#(
    parameter int NUM_FU = WB_FU_NUM
);
    ex_update              fu_update [NUM_FU];
    ex_update              wb_update;
    logic                  wb_ready;
    logic [NUM_FU-1:0]     fu_stall;
    logic                  overflow_err;

    modport master (
        output fu_update,
        output wb_ready,
        input  wb_update,
        input  fu_stall,
        input  overflow_err
    );

    modport slave (
        input  fu_update,
        input  wb_ready,
        output wb_update,
        output fu_stall,
        output overflow_err
    );
endinterface

// File: rtl/wb_collector_fifo.sv
// Single-clock result FIFO; a push at full is accepted when a pop frees a slot
// in the same cycle.
module wb_fifo
    import wb_collector_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry       push_data,
    input  logic          pop,
    output wb_entry       pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    wb_entry         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            do_push, do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset so it maps onto plain RAM; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr_reg] <= push_data;
    end
endmodule

// File: rtl/wb_collector.sv
// Collects per-unit results into FIFOs and drains them round-robin through a
// single registered valid/ready writeback port.
module wb_collector
    import wb_collector_pkg::*;
#(
    parameter int NUM_FU       = WB_FU_NUM,
    parameter int DEPTH        = WB_FIFO_DEPTH,
    parameter int STALL_MARGIN = WB_STALL_MARGIN
) (
    input  logic           clk,
    input  logic           rst,
    wb_collector_if.slave  bus
);
    localparam int GW = $clog2(NUM_FU);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LEVEL = CW'(DEPTH - STALL_MARGIN);

    logic [NUM_FU-1:0] fu_valid;
    logic [NUM_FU-1:0] fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]     fifo_count [NUM_FU];
    wb_entry           fifo_data  [NUM_FU];

    ex_update          wb_reg, wb_next;
    logic [GW-1:0]     last_grant_reg, last_grant_next;
    logic              overflow_reg, overflow_next;
    logic [GW-1:0]     grant_next;
    logic              grant_found;
    logic              load;
    logic              overflow_hit;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_unit
            assign fu_valid[gi]     = bus.fu_update[gi].valid;
            assign fifo_pop[gi]     = load && (grant_next == GW'(gi));
            assign bus.fu_stall[gi] = (fifo_count[gi] >= STALL_LEVEL);

            wb_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (fu_valid[gi]),
                .push_data (to_entry(bus.fu_update[gi])),
                .pop       (fifo_pop[gi]),
                .pop_data  (fifo_data[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .count     (fifo_count[gi])
            );
        end
    endgenerate

    // Round-robin: first non-empty unit after the last one granted.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_next  = last_grant_reg;
        idx         = 0;
        for (int off = 1; off <= NUM_FU; off++) begin
            idx = (int'(last_grant_reg) + off) % NUM_FU;
            if (!grant_found && !fifo_empty[idx]) begin
                grant_found = 1'b1;
                grant_next  = GW'(idx);
            end
        end
    end

    assign load         = grant_found && (!wb_reg.valid || bus.wb_ready);
    assign overflow_hit = |(fu_valid & fifo_full & ~fifo_pop);

    always_comb begin
        wb_next         = wb_reg;
        last_grant_next = last_grant_reg;
        overflow_next   = overflow_reg | overflow_hit;
        if (load) begin
            wb_next         = from_entry(fifo_data[grant_next]);
            last_grant_next = grant_next;
        end else if (wb_reg.valid && bus.wb_ready) begin
            wb_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg         <= '0;
            last_grant_reg <= GW'(NUM_FU - 1);
            overflow_reg   <= 1'b0;
        end else begin
            wb_reg         <= wb_next;
            last_grant_reg <= last_grant_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign bus.wb_update    = wb_reg;
    assign bus.overflow_err = overflow_reg;
endmodule

// File: tb/tb_wb_collector.sv
// Randomized and directed bench for wb_collector against a queue-based
// reference model of the collector's buffering and arbitration rules.
module tb_wb_collector;
    import wb_collector_pkg::*;

    localparam int N = 4;
    localparam int D = 8;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_collector_if #(.NUM_FU(N)) bus ();

    wb_collector #(.NUM_FU(N), .DEPTH(D), .STALL_MARGIN(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "reset";

    ex_update mq [N][$];
    ex_update m_out;
    int       m_last;
    bit       m_ovf;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic ex_update mk(int t, logic [31:0] d);
        ex_update e;
        e.valid           = 1'b1;
        e.destination     = 5'($urandom);
        e.ticket          = 6'(t);
        e.data            = d;
        e.valid_exception = 1'($urandom);
        e.cause           = 4'($urandom);
        return e;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) bus.fu_update[i] = '0;
    endtask

    // Reference behaviour for one clock edge, using the inputs present now.
    task automatic model_step();
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_out  = '0;
            m_last = N - 1;
            m_ovf  = 1'b0;
            return;
        end
        if (m_out.valid && bus.wb_ready)
            $display("[%s] writeback ticket=%0d data=%h dest=%0d", phase, m_out.ticket, m_out.data, m_out.destination);
        g = -1;
        if (!m_out.valid || bus.wb_ready) begin
            for (int off = 1; off <= N; off++) begin
                int u;
                u = (m_last + off) % N;
                if (g < 0 && mq[u].size() > 0) g = u;
            end
        end
        if (g >= 0) begin
            m_out       = mq[g].pop_front();
            m_out.valid = 1'b1;
            m_last      = g;
        end else if (m_out.valid && bus.wb_ready) begin
            m_out = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.fu_update[i].valid) begin
                if (mq[i].size() < D) mq[i].push_back(bus.fu_update[i]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_stall;
        for (int i = 0; i < N; i++) exp_stall[i] = ((D - mq[i].size()) <= M);
        check_eq({phase, ".valid"}, 64'(bus.wb_update.valid), 64'(m_out.valid));
        if (m_out.valid) check_eq({phase, ".wb"}, 64'(bus.wb_update), 64'(m_out));
        check_eq({phase, ".stall"}, 64'(bus.fu_stall), 64'(exp_stall));
        check_eq({phase, ".ovf"}, 64'(bus.overflow_err), 64'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        clear_inputs();
        bus.wb_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        check_eq("reset.wb", 64'(bus.wb_update), 64'd0);
        check_eq("reset.stall", 64'(bus.fu_stall), 64'd0);
        check_eq("reset.ovf", 64'(bus.overflow_err), 64'd0);
        rst = 1'b0;

        phase = "single";
        bus.fu_update[2] = mk(5, 32'hDEAD);
        step();
        clear_inputs();
        for (int c = 0; c < 4; c++) step();

        phase = "four";
        for (int i = 0; i < N; i++) bus.fu_update[i] = mk(10 + i, $urandom);
        step();
        clear_inputs();
        for (int c = 0; c < 6; c++) step();

        phase = "backpressure";
        for (int c = 0; c < 10; c++) begin
            bus.wb_ready = !(c >= 2 && c <= 6);
            if (c < 3) bus.fu_update[0] = mk(20 + c, $urandom);
            else clear_inputs();
            step();
        end

        phase = "overflow";
        bus.wb_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.fu_update[1] = mk(30 + c, $urandom);
            step();
        end
        clear_inputs();
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        phase = "full_pop";
        bus.wb_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mq[1].size() < D) bus.fu_update[1] = mk(c, $urandom);
            else clear_inputs();
            step();
        end
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.fu_update[1] = mk(40 + c, $urandom);
            step();
        end
        check_eq("full_pop.no_ovf", 64'(bus.overflow_err), 64'd0);
        clear_inputs();
        for (int c = 0; c < 12; c++) step();

        phase = "fairness";
        for (int c = 0; c < 10; c++) begin
            bus.fu_update[0] = mk(c, $urandom);
            bus.fu_update[3] = mk(32 + c, $urandom);
            step();
        end
        clear_inputs();
        for (int c = 0; c < 24; c++) step();

        phase = "reset_mid";
        bus.wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.fu_update[0] = mk(50 + c, $urandom);
            if (c < 2) bus.fu_update[2] = mk(55 + c, $urandom);
            else bus.fu_update[2] = '0;
            step();
        end
        clear_inputs();
        step();
        rst = 1'b1;
        bus.fu_update[3] = mk(60, $urandom);
        step();
        rst = 1'b0;
        clear_inputs();
        check_eq("reset_mid.valid", 64'(bus.wb_update.valid), 64'd0);
        check_eq("reset_mid.stall", 64'(bus.fu_stall), 64'd0);
        check_eq("reset_mid.ovf", 64'(bus.overflow_err), 64'd0);
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();

        phase = "random";
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 35) bus.fu_update[i] = mk($urandom_range(0, 63), $urandom);
                else bus.fu_update[i] = '0;
            end
            bus.wb_ready = ($urandom_range(0, 99) < 70);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        clear_inputs();
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 40; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
